// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl -- multi-cycle instruction sequencer for the basic processor.
//
// Walks every instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Instructions are fetched over an imem req/ack handshake. The instruction
// register drives the datapath, and alu_en marks the cycle in which the
// datapath result is sampled. Loads run over a dmem req/ack handshake. Each
// instruction ends with exactly one register-file write strobe. Illegal
// opcodes and handshakes that wait too long park the sequencer in TRAP until
// reset.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   imem_req/addr         fetch request and address (= pc)
//   imem_ack/rdata        fetch completion and instruction word
//   instruction           latched instruction register
//   alu_en, alu_result    datapath sample strobe, datapath result
//   dmem_req/addr/byte    load request, address, byte(1)/word(0) select
//   dmem_ack/rdata        load completion and data
//   rf_we/waddr/wdata     register-file write port
//   pc, retired           program counter, retired-instruction count
//   illegal, bus_err      sticky trap flags
module instr_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instruction,
  output logic             alu_en,
  input  logic [31:0]      alu_result,
  output logic             dmem_req,
  output logic [31:0]      dmem_addr,
  output logic             dmem_byte,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic             bus_err
);

  localparam int                TO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_LDB = 7'h10;
  localparam logic [6:0] OP_LDW = 7'h11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t            state_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       ir_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic [TO_W-1:0]   tmo_cnt_reg;
  logic              imem_req_reg;
  logic              dmem_req_reg;
  logic [31:0]       dmem_addr_reg;
  logic              dmem_byte_reg;
  logic              alu_en_reg;
  logic              rf_we_reg;
  logic [31:0]       rf_wdata_reg;
  logic              illegal_reg;
  logic              bus_err_reg;

  logic [6:0]        opcode;
  logic              op_legal;
  logic              op_load;

  assign opcode   = ir_reg[31:25];
  assign op_load  = (opcode == OP_LDB) || (opcode == OP_LDW);
  assign op_legal = (opcode == OP_ADD) || (opcode == OP_SUB) || op_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      retired_reg   <= '0;
      tmo_cnt_reg   <= '0;
      imem_req_reg  <= 1'b0;
      dmem_req_reg  <= 1'b0;
      dmem_addr_reg <= '0;
      dmem_byte_reg <= 1'b0;
      alu_en_reg    <= 1'b0;
      rf_we_reg     <= 1'b0;
      rf_wdata_reg  <= '0;
      illegal_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // Coming out of reset the request is still low; raise it here.
          // Any ack seen before the request is up is ignored.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
            tmo_cnt_reg  <= '0;
          end else if (imem_ack) begin
            ir_reg       <= imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= S_DECODE;
          end else if (tmo_cnt_reg == TO_LAST) begin
            // The ack check above has priority, so an ack in the
            // final allowed cycle still completes the fetch.
            bus_err_reg  <= 1'b1;
            imem_req_reg <= 1'b0;
            state_reg    <= S_TRAP;
          end else begin
            tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
          end
        end

        S_DECODE: begin
          if (op_legal) begin
            alu_en_reg  <= 1'b1;
            state_reg   <= S_EXEC;
          end else begin
            illegal_reg <= 1'b1;
            state_reg   <= S_TRAP;
          end
        end

        S_EXEC: begin
          alu_en_reg <= 1'b0;
          if (op_load) begin
            dmem_addr_reg <= alu_result;
            dmem_byte_reg <= (opcode == OP_LDB);
            dmem_req_reg  <= 1'b1;
            tmo_cnt_reg   <= '0;
            state_reg     <= S_MEM;
          end else begin
            rf_wdata_reg  <= alu_result;
            rf_we_reg     <= 1'b1;
            state_reg     <= S_WB;
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            rf_wdata_reg <= dmem_byte_reg ? {24'h00_0000, dmem_rdata[7:0]} : dmem_rdata;
            dmem_req_reg <= 1'b0;
            rf_we_reg    <= 1'b1;
            state_reg    <= S_WB;
          end else if (tmo_cnt_reg == TO_LAST) begin
            bus_err_reg  <= 1'b1;
            dmem_req_reg <= 1'b0;
            state_reg    <= S_TRAP;
          end else begin
            tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
          end
        end

        S_WB: begin
          rf_we_reg    <= 1'b0;
          pc_reg       <= pc_reg + 32'd4;
          retired_reg  <= retired_reg + 1'b1;
          // Raise the next fetch request directly so that back-to-back
          // instructions have no idle cycle between them.
          imem_req_reg <= 1'b1;
          tmo_cnt_reg  <= '0;
          state_reg    <= S_FETCH;
        end

        S_TRAP: begin
          // Everything stays frozen until reset.
        end

        default: state_reg <= S_TRAP;
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instruction = ir_reg;
  assign alu_en      = alu_en_reg;
  assign dmem_req    = dmem_req_reg;
  assign dmem_addr   = dmem_addr_reg;
  assign dmem_byte   = dmem_byte_reg;
  assign rf_we       = rf_we_reg;
  assign rf_waddr    = ir_reg[24:20];
  assign rf_wdata    = rf_wdata_reg;
  assign pc          = pc_reg;
  assign retired     = retired_reg;
  assign illegal     = illegal_reg;
  assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Testbench for instr_seq_ctrl.
//
// A transaction-level model turns each instruction (word, ack delays, data)
// into a cycle-by-cycle schedule. Each schedule entry holds the stimulus for
// one cycle and the outputs expected in that cycle. A single loop drives and
// compares every entry. Observed writebacks are also logged, so that a few
// hand-computed literal values can be checked at the end.
`timescale 1ns/1ps
module tb_instr_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;  // start near the top so pc wraps
  localparam int          TMO    = 6;
  localparam int          CW     = 4;              // narrow so retired wraps

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, imem_ack, alu_en, dmem_req, dmem_byte, dmem_ack;
  logic          rf_we, illegal, bus_err;
  logic [31:0]   imem_addr, imem_rdata, instruction, alu_result;
  logic [31:0]   dmem_addr, dmem_rdata, rf_wdata, pc;
  logic [4:0]    rf_waddr;
  logic [CW-1:0] retired;

  instr_seq_ctrl #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .alu_en(alu_en), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_byte(dmem_byte),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .retired(retired), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, i_ack, d_ack;
    logic [31:0]   i_rdata, d_rdata, alu;
    logic          e_ireq, e_alu_en, e_dreq, e_we, e_ill, e_berr, e_dbyte;
    logic [31:0]   e_pc, e_instr, e_daddr, e_wdata;
    logic [4:0]    e_waddr;
    logic [CW-1:0] e_ret;
  } cyc_t;

  cyc_t sched[$];

  // Architectural state of the model
  logic [31:0]   m_pc, m_ir;
  logic [CW-1:0] m_ret;
  bit            m_ill, m_berr, m_idle_fetch;

  int checks = 0;
  int errors = 0;

  // Observation logs for the literal checks
  int          wr_cyc[$];
  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_pc[$];
  int          alu_cyc[$];
  logic [31:0] dm_addr[$];
  logic        dm_byte[$];

  function automatic cyc_t base();
    cyc_t c;
    c.rst = 1'b0; c.i_ack = 1'b0; c.d_ack = 1'b0;
    c.i_rdata = $urandom; c.d_rdata = $urandom; c.alu = $urandom;
    c.e_ireq = 1'b0; c.e_alu_en = 1'b0; c.e_dreq = 1'b0; c.e_we = 1'b0;
    c.e_ill = m_ill; c.e_berr = m_berr; c.e_dbyte = 1'b0;
    c.e_pc = m_pc; c.e_instr = m_ir; c.e_daddr = '0; c.e_wdata = '0;
    c.e_waddr = '0; c.e_ret = m_ret;
    return c;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_ir = '0; m_ret = '0;
    m_ill = 1'b0; m_berr = 1'b0; m_idle_fetch = 1'b1;
  endtask

  // Trapped or idle cycles; stray acks must have no effect.
  task automatic gen_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base();
      c.i_ack = 1'($urandom_range(0, 1));
      c.d_ack = 1'($urandom_range(0, 1));
      sched.push_back(c);
    end
  endtask

  task automatic gen_reset();
    cyc_t c;
    c = base();
    c.rst = 1'b1;
    sched.push_back(c);
    model_reset();
  endtask

  // fdly/mdly: wait cycles before ack (>= TMO or < 0 means never acked).
  // mrst: MEM wait cycle in which reset is asserted instead (-1 = none).
  task automatic gen_instr(input logic [31:0] word, input int fdly, input logic [31:0] alu,
                           input int mdly, input logic [31:0] drd, input int mrst);
    cyc_t        c;
    bit          acked;
    logic [6:0]  op;
    logic [31:0] wd;
    if (m_ill || m_berr) return;
    if (m_idle_fetch) begin
      c = base();
      c.i_ack = 1'b1;
      c.d_ack = 1'b1;
      sched.push_back(c);
      m_idle_fetch = 1'b0;
    end
    acked = 1'b0;
    for (int i = 0; i < TMO && !acked; i++) begin
      c = base();
      c.e_ireq = 1'b1;
      if (i == fdly) begin
        c.i_ack = 1'b1; c.i_rdata = word; acked = 1'b1;
      end
      sched.push_back(c);
    end
    if (!acked) begin m_berr = 1'b1; return; end
    m_ir = word;
    op = word[31:25];
    sched.push_back(base());  // decode
    if (!(op == 7'h00 || op == 7'h01 || op == 7'h10 || op == 7'h11)) begin
      m_ill = 1'b1;
      return;
    end
    c = base();
    c.e_alu_en = 1'b1;
    c.alu = alu;
    sched.push_back(c);
    if (op == 7'h10 || op == 7'h11) begin
      acked = 1'b0;
      for (int i = 0; i < TMO && !acked; i++) begin
        c = base();
        c.e_dreq = 1'b1; c.e_daddr = alu; c.e_dbyte = (op == 7'h10);
        if (i == mrst) begin
          c.rst = 1'b1;
          sched.push_back(c);
          model_reset();
          return;
        end
        if (i == mdly) begin
          c.d_ack = 1'b1; c.d_rdata = drd; acked = 1'b1;
        end
        sched.push_back(c);
      end
      if (!acked) begin m_berr = 1'b1; return; end
      wd = (op == 7'h10) ? {24'h0, drd[7:0]} : drd;
    end else begin
      wd = alu;
    end
    c = base();
    c.e_we = 1'b1; c.e_waddr = word[24:20]; c.e_wdata = wd;
    sched.push_back(c);
    m_pc = m_pc + 32'd4;
    m_ret = m_ret + 1'b1;
  endtask

  task automatic gen_random(input int n);
    logic [6:0] op;
    int r, fd, md;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 19);
      if (r < 5)       op = 7'h00;
      else if (r < 10) op = 7'h01;
      else if (r < 15) op = 7'h10;
      else if (r < 19) op = 7'h11;
      else begin
        op = 7'($urandom_range(0, 127));
        while (op == 7'h00 || op == 7'h01 || op == 7'h10 || op == 7'h11)
          op = 7'($urandom_range(0, 127));
      end
      fd = ($urandom_range(0, 12) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
      md = ($urandom_range(0, 12) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 3);
      gen_instr({op, 25'($urandom)}, fd, $urandom, md, $urandom, -1);
      if (m_ill || m_berr) begin
        gen_idle(2);
        gen_reset();
      end
    end
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    cyc_t c;
    int   cyc;
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = '0; dmem_rdata = '0; alu_result = '0;

    model_reset();
    // Directed cases
    gen_instr(32'h0030_8800, 0, 32'd7, 0, 32'h0, -1);                    // ADD
    gen_instr(32'h0030_8801, 3, 32'h0000_1234, 0, 32'h0, -1);            // SUB, late ack
    gen_instr(32'h2000_8050, 0, 32'h50, 0, 32'hAABB_CCDD, -1);           // LDB
    gen_instr(32'h2200_8050, 0, 32'h50, 0, 32'hAABB_CCDD, -1);           // LDW
    gen_instr(32'h0050_0000, TMO - 1, 32'h11, 0, 32'h0, -1);             // fetch ack at the limit
    gen_instr(32'h2270_0000, 1, 32'h80, TMO - 1, 32'h1357_9BDF, -1);     // load ack at the limit
    for (int i = 0; i < 18; i++)                                         // retired wraps
      gen_instr({7'h00, 25'($urandom)}, $urandom_range(0, 2), $urandom, 0, 32'h0, -1);
    gen_instr(32'hFE00_0000, 0, 32'h0, 0, 32'h0, -1);                    // illegal
    gen_idle(3);
    gen_reset();
    gen_instr(32'h2200_8050, 0, 32'h60, -1, 32'h0, -1);                  // dmem never acks
    gen_idle(3);
    gen_reset();
    gen_instr(32'h0010_0000, TMO, 32'h0, 0, 32'h0, -1);                  // imem never acks
    gen_idle(2);
    gen_reset();
    gen_instr(32'h2200_8050, 0, 32'h70, 3, 32'h0, 1);                    // reset during MEM
    gen_instr(32'h0030_8800, 0, 32'h99, 0, 32'h0, -1);
    gen_random(150);

    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      reset = c.rst; imem_ack = c.i_ack; imem_rdata = c.i_rdata;
      dmem_ack = c.d_ack; dmem_rdata = c.d_rdata; alu_result = c.alu;

      chk("imem_req", cyc, 32'(imem_req), 32'(c.e_ireq));
      chk("alu_en", cyc, 32'(alu_en), 32'(c.e_alu_en));
      chk("dmem_req", cyc, 32'(dmem_req), 32'(c.e_dreq));
      chk("rf_we", cyc, 32'(rf_we), 32'(c.e_we));
      chk("pc", cyc, pc, c.e_pc);
      chk("retired", cyc, 32'(retired), 32'(c.e_ret));
      chk("illegal", cyc, 32'(illegal), 32'(c.e_ill));
      chk("bus_err", cyc, 32'(bus_err), 32'(c.e_berr));
      chk("instruction", cyc, instruction, c.e_instr);
      if (c.e_ireq) chk("imem_addr", cyc, imem_addr, c.e_pc);
      if (c.e_dreq) begin
        chk("dmem_addr", cyc, dmem_addr, c.e_daddr);
        chk("dmem_byte", cyc, 32'(dmem_byte), 32'(c.e_dbyte));
      end
      if (c.e_we) begin
        chk("rf_waddr", cyc, 32'(rf_waddr), 32'(c.e_waddr));
        chk("rf_wdata", cyc, rf_wdata, c.e_wdata);
      end

      if (rf_we === 1'b1) begin
        wr_cyc.push_back(cyc); wr_addr.push_back(rf_waddr);
        wr_data.push_back(rf_wdata); wr_pc.push_back(pc);
        $display("wb   cyc=%0d r%0d <= %h pc=%h retired=%0d", cyc, rf_waddr, rf_wdata, pc, retired);
      end
      if (alu_en === 1'b1) alu_cyc.push_back(cyc);
      if (c.e_dreq && dmem_req === 1'b1 && (dm_addr.size() == 0 || c.d_ack)) begin
        dm_addr.push_back(dmem_addr); dm_byte.push_back(dmem_byte);
      end
      if (c.rst) $display("rst  cyc=%0d", cyc);

      @(posedge clk);
      #1;
      cyc++;
    end

    // Hand-computed expectations for the first directed instructions
    chk("wb_log_size", cyc, 32'(wr_cyc.size() >= 4), 32'd1);
    chk("dm_log_size", cyc, 32'(dm_addr.size() >= 2), 32'd1);
    if (wr_cyc.size() >= 4 && alu_cyc.size() >= 1 && dm_addr.size() >= 2) begin
      chk("t1_alu_cycle", 0, 32'(alu_cyc[0]), 32'd3);
      chk("t1_wb_cycle", 0, 32'(wr_cyc[0]), 32'd4);
      chk("t1_waddr", 0, 32'(wr_addr[0]), 32'd3);
      chk("t1_wdata", 0, wr_data[0], 32'd7);
      chk("t1_pc", 0, wr_pc[0], 32'hFFFF_FFF8);
      chk("t2_wb_gap", 0, 32'(wr_cyc[1] - wr_cyc[0]), 32'd7);
      chk("t3_pc_wrapped", 0, wr_pc[2], 32'h0000_0000);
      chk("t3_waddr", 0, 32'(wr_addr[2]), 32'd0);
      chk("t3_wdata", 0, wr_data[2], 32'h0000_00DD);
      chk("t3_dmem_addr", 0, dm_addr[0], 32'h0000_0050);
      chk("t3_dmem_byte", 0, 32'(dm_byte[0]), 32'd1);
      chk("t4_dmem_byte", 0, 32'(dm_byte[1]), 32'd0);
      chk("t4_wdata", 0, wr_data[3], 32'hAABB_CCDD);
      chk("t4_wb_gap", 0, 32'(wr_cyc[3] - wr_cyc[2]), 32'd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
